// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, with programmable
// wait states in front of a word-organised, byte-enabled block RAM.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wren,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_error
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t         r_state;
    logic           r_req_ready;
    logic           r_rsp_valid;
    logic [31:0]    r_rsp_rdata;
    logic           r_rsp_error;
    logic [3:0]     r_cnt;
    logic           r_wren;
    logic [2:0]     r_funct3;
    logic [AW-1:0]  r_idx;
    logic [1:0]     r_lane;
    logic [31:0]    r_wdata;
    logic           r_err;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic [31:0]    w_offset;
    logic           w_legal;
    logic           w_misaligned;
    logic           w_err;
    logic [3:0]     w_be;
    logic [31:0]    w_wlanes;
    logic [31:0]    w_word;
    logic [31:0]    w_shifted;
    logic [31:0]    w_load;
    logic           w_we;

    // Request validation, evaluated on the incoming request at accept time.
    always_comb begin
        w_offset     = i_req_addr - BASE_ADDR;
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        case (i_req_funct3)
            3'b000: w_legal = 1'b1;
            3'b001: begin w_legal = 1'b1;        w_misaligned = i_req_addr[0];    end
            3'b010: begin w_legal = 1'b1;        w_misaligned = |i_req_addr[1:0]; end
            3'b100: w_legal = !i_req_wren;
            3'b101: begin w_legal = !i_req_wren; w_misaligned = i_req_addr[0];    end
            default: w_legal = 1'b0;
        endcase
        // Unsigned wrap makes addresses below BASE_ADDR land above SPAN as well.
        w_err = !w_legal || w_misaligned || (w_offset >= SPAN);
    end

    // Store lane steering and load extraction for the latched request.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   begin w_be = 4'b0001 << r_lane; w_wlanes = {4{r_wdata[7:0]}};  end
            2'b01:   begin w_be = 4'b0011 << r_lane; w_wlanes = {2{r_wdata[15:0]}}; end
            default: begin w_be = 4'b1111;           w_wlanes = r_wdata;            end
        endcase
        w_word    = r_mem[r_idx];
        w_shifted = w_word >> {r_lane, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
        w_we = (r_state == S_ACCESS) && r_wren && !r_err;
    end

    // RAM is never reset; a write only happens on the ACCESS cycle.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
            r_cnt       <= 4'd0;
            r_wren      <= 1'b0;
            r_funct3    <= 3'd0;
            r_idx       <= '0;
            r_lane      <= 2'd0;
            r_wdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid && r_req_ready) begin
                        r_wren      <= i_req_wren;
                        r_funct3    <= i_req_funct3;
                        r_idx       <= w_offset[AW+1:2];
                        r_lane      <= i_req_addr[1:0];
                        r_wdata     <= i_req_wdata;
                        r_err       <= w_err;
                        r_req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= r_err;
                    r_rsp_rdata <= (r_err || r_wren) ? 32'd0 : w_load;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_error = r_rsp_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// checked against a byte-addressed memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 2048;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int unsigned WAITC = 2;
    localparam int          LAT   = WAITC + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wren;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [0:4*DEPTH-1];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wren(req_wren),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    // Reference behaviour: byte-array memory, size/sign from funct3, error rules by arithmetic.
    task automatic model_txn(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int size;
        int off;
        logic legal;
        logic oor;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = wren ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        oor   = (addr < BASE) || (addr >= BASE + 32'(4 * DEPTH));
        er    = !legal || oor || ((addr & 32'(size - 1)) != 32'd0);
        rd    = 32'd0;
        if (!er) begin
            off = int'(addr - BASE);
            if (wren) begin
                for (int k = 0; k < size; k++) model[off + k] = wdata[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < size; k++) v[8*k +: 8] = model[off + k];
                if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
                rd = v;
            end
        end
    endtask

    // Present one request, then drive junk (ignored) request inputs until the response appears.
    task automatic issue(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_wren = wren; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b1; req_wren = 1'b1; req_funct3 = 3'b010;
        req_addr = BASE + 32'($urandom_range(0, 15) * 4); req_wdata = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        if (!rsp_valid) lat = -1;
    endtask

    task automatic complete(input int hold);
        repeat (hold) @(negedge clk);
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got=%b exp=0", rsp_error); end
    endtask

    task automatic test_word_access();
        logic        w[2]  = '{1'b1, 1'b0};
        logic [31:0] a[2]  = '{32'h2000, 32'h2000};
        logic [31:0] d[2]  = '{32'hDEADBEEF, 32'h0};
        logic [31:0] ex[2] = '{32'h0, 32'hDEADBEEF};
        logic [31:0] mrd;
        logic        mer;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            issue(w[i], 3'b010, a[i], d[i], lat);
            model_txn(w[i], 3'b010, a[i], d[i], mrd, mer);
            checks++; if (lat != LAT) begin errors++; $display("FAIL word_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
            checks++; if (rsp_rdata !== ex[i]) begin errors++; $display("FAIL word_rdata[%0d] got=%h exp=%h", i, rsp_rdata, ex[i]); end
            checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL word_error[%0d] got=%b exp=0", i, rsp_error); end
            complete(0);
        end
    endtask

    task automatic test_subword();
        logic        w[9]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
        logic [2:0]  f[9]  = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b101, 3'b001};
        logic [31:0] a[9]  = '{32'h2004, 32'h2006, 32'h2006, 32'h2006, 32'h2004,
                               32'h2002, 32'h2002, 32'h2002, 32'h2003};
        logic [31:0] d[9]  = '{32'h11223344, 32'h80, 0, 0, 0, 32'hBEEF, 0, 0, 0};
        logic [31:0] ex[9] = '{0, 0, 32'hFFFFFF80, 32'h00000080, 32'h11803344,
                               0, 32'hFFFFBEEF, 32'h0000BEEF, 0};
        logic        ee[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic [31:0] mrd;
        logic        mer;
        int          lat;
        for (int i = 0; i < 9; i++) begin
            issue(w[i], f[i], a[i], d[i], lat);
            model_txn(w[i], f[i], a[i], d[i], mrd, mer);
            checks++; if (lat != LAT) begin errors++; $display("FAIL sub_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
            checks++; if (rsp_rdata !== ex[i]) begin errors++; $display("FAIL sub_rdata[%0d] got=%h exp=%h", i, rsp_rdata, ex[i]); end
            checks++; if (rsp_error !== ee[i]) begin errors++; $display("FAIL sub_error[%0d] got=%b exp=%b", i, rsp_error, ee[i]); end
            complete(0);
        end
    endtask

    task automatic test_errors();
        logic        w[6]  = '{1, 1, 0, 0, 0, 1};
        logic [2:0]  f[6]  = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b100};
        logic [31:0] a[6]  = '{32'h2001, 32'h1FFC, 32'h2000, 32'h2004, 32'h2000, 32'h2000};
        logic [31:0] d[6]  = '{32'h55555555, 32'h66666666, 0, 0, 0, 32'h77};
        logic [31:0] ex[6] = '{0, 0, 32'hBEEFBEEF, 32'h11803344, 0, 0};
        logic        ee[6] = '{1, 1, 0, 0, 1, 1};
        logic [31:0] mrd;
        logic        mer;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            issue(w[i], f[i], a[i], d[i], lat);
            model_txn(w[i], f[i], a[i], d[i], mrd, mer);
            checks++; if (lat != LAT) begin errors++; $display("FAIL err_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
            checks++; if (rsp_rdata !== ex[i]) begin errors++; $display("FAIL err_rdata[%0d] got=%h exp=%h", i, rsp_rdata, ex[i]); end
            checks++; if (rsp_error !== ee[i]) begin errors++; $display("FAIL err_error[%0d] got=%b exp=%b", i, rsp_error, ee[i]); end
            complete(0);
        end
    endtask

    task automatic test_hold();
        int lat;
        issue(1'b0, 3'b010, 32'h2004, 32'h0, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL hold_latency got=%0d exp=%0d", lat, LAT); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got=%b exp=1", c, rsp_valid); end
            checks++; if (rsp_rdata !== 32'h11803344) begin errors++; $display("FAIL hold_rdata[%0d] got=%h exp=11803344", c, rsp_rdata); end
            checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL hold_error[%0d] got=%b exp=0", c, rsp_error); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready[%0d] got=%b exp=0", c, req_ready); end
        end
        complete(0);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_done_valid got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_done_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] mrd;
        logic        mer;
        int          lat;
        issue(1'b1, 3'b010, 32'h2010, 32'h01234567, lat);
        model_txn(1'b1, 3'b010, 32'h2010, 32'h01234567, mrd, mer);
        complete(0);
        issue(1'b0, 3'b010, 32'h2004, 32'h0, lat);
        complete(0);
        @(negedge clk);
        req_valid = 1'b1; req_wren = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2010; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL abort_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL abort_rsp_error got=%b exp=0", rsp_error); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h2010, 32'h0, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL abort_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (rsp_rdata !== 32'h01234567) begin errors++; $display("FAIL abort_old_data got=%h exp=01234567", rsp_rdata); end
        complete(0);
    endtask

    task automatic test_back_to_back();
        logic        wren;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic        mer;
        int          lat;
        int          sel;
        for (int i = 0; i < 17; i++) begin
            addr = (i == 16) ? 32'h3FFC : BASE + 32'(4 * i);
            wdata = $urandom;
            issue(1'b1, 3'b010, addr, wdata, lat);
            model_txn(1'b1, 3'b010, addr, wdata, mrd, mer);
            complete(0);
        end
        for (int i = 0; i < 60; i++) begin
            wren  = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            sel   = $urandom_range(0, 9);
            if (sel < 8)       addr = BASE + 32'($urandom_range(0, 63));
            else if (sel == 8) addr = 32'h3FFC + 32'($urandom_range(0, 7));
            else               addr = 32'h1FF8 + 32'($urandom_range(0, 7));
            issue(wren, f3, addr, wdata, lat);
            model_txn(wren, f3, addr, wdata, mrd, mer);
            checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
            checks++; if (rsp_rdata !== mrd) begin errors++; $display("FAIL rnd_rdata[%0d] w=%b f3=%0d a=%h got=%h exp=%h", i, wren, f3, addr, rsp_rdata, mrd); end
            checks++; if (rsp_error !== mer) begin errors++; $display("FAIL rnd_error[%0d] w=%b f3=%0d a=%h got=%b exp=%b", i, wren, f3, addr, rsp_error, mer); end
            complete($urandom_range(0, 2));
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wren = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_word_access();
        test_subword();
        test_errors();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
